// File: rtl/intercon_xbar_cfg_if.sv
// Bus bundle for one crossbar instance: serial config chain, commit control,
// routing tracks in and routed clb pins out.
interface intercon_xbar_cfg_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 5
);
  logic              shift_en;
  logic              shift_i;
  logic              shift_o;
  logic              cfg_load;
  logic              cfg_valid;
  logic              cfg_err;
  logic [N_IN-1:0]   trk_in;
  logic [N_OUT-1:0]  pin_out;

  modport master (
    output shift_en, shift_i, cfg_load, trk_in,
    input  shift_o, cfg_valid, cfg_err, pin_out
  );

  modport slave (
    input  shift_en, shift_i, cfg_load, trk_in,
    output shift_o, cfg_valid, cfg_err, pin_out
  );
endinterface

// File: rtl/intercon_xbar_cfg.sv
// Programmable crossbar: serially loaded shadow config, atomic commit into the
// active config, per-pin track select with optional output register.
module intercon_xbar_cfg #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 5,
  parameter int SEL_W = 4
) (
  input  logic                  shift_clk,
  input  logic                  shift_rst_n,
  intercon_xbar_cfg_if.slave    bus
);

  localparam int FIELD_W  = SEL_W + 1;
  localparam int CFG_BITS = N_OUT * FIELD_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [N_OUT-1:0]    pin_q, pin_d;

  logic [N_OUT-1:0]    mux_raw;
  logic [N_OUT-1:0]    mux_gated;
  logic [N_OUT-1:0]    reg_mode;
  logic [N_OUT-1:0]    out_sel;

  // A load that is simultaneous with a shift is ignored outright: no commit, no error.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (bus.shift_en) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], bus.shift_i};
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.cfg_load) begin
      cnt_d = '0;
      if (cnt_q == CNT_W'(CFG_BITS)) begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end
  end

  // sel = 0 and sel > N_IN both fall through to the constant-0 default.
  always_comb begin
    mux_raw  = '0;
    reg_mode = '0;
    for (int j = 0; j < N_OUT; j++) begin
      reg_mode[j] = active_q[j*FIELD_W];
      for (int k = 1; k <= N_IN; k++) begin
        if (active_q[j*FIELD_W+1 +: SEL_W] == SEL_W'(k)) mux_raw[j] = bus.trk_in[k-1];
      end
    end
  end

  assign mux_gated = valid_q ? mux_raw : '0;
  assign pin_d     = mux_gated;

  always_comb begin
    out_sel = '0;
    for (int j = 0; j < N_OUT; j++) begin
      out_sel[j] = reg_mode[j] ? pin_q[j] : mux_gated[j];
    end
  end

  always_ff @(posedge shift_clk or negedge shift_rst_n) begin
    if (!shift_rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      pin_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      pin_q    <= pin_d;
    end
  end

  assign bus.pin_out   = out_sel & {N_OUT{valid_q}};
  assign bus.shift_o   = shadow_q[CFG_BITS-1];
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_intercon_xbar_cfg.sv
// Directed bench for intercon_xbar_cfg with a queue of expected values that
// are pushed as stimulus is applied and popped as DUT outputs are sampled.
module tb_intercon_xbar_cfg;

  logic clk;
  logic rst_n;

  intercon_xbar_cfg_if #(.N_IN(8), .N_OUT(5)) bus ();

  intercon_xbar_cfg #(.N_IN(8), .N_OUT(5), .SEL_W(4)) dut (
    .shift_clk   (clk),
    .shift_rst_n (rst_n),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // out0: sel=3 combinational, out1: sel=8 registered
  localparam logic [24:0] STREAM_A = 25'b00000_00000_00000_10001_00110;
  // out0: sel=15, out1: sel=1 comb, out2: sel=8 reg, out3: sel=0, out4: sel=5 comb
  localparam logic [24:0] STREAM_B = 25'b01010_00000_10001_00010_11110;

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t item;
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0h expected=<queued value>", obs);
    end else begin
      item = sb.pop_front();
      assert (obs === item.exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.shift_en = 1'b0;
    bus.shift_i  = 1'b0;
    bus.cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.shift_en = 1'b1;
      bus.shift_i  = w[i];
      @(posedge clk);
      #1;
    end
    bus.shift_en = 1'b0;
    bus.shift_i  = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_load = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    rst_n        = 1'b0;
    bus.shift_en = 1'b0;
    bus.shift_i  = 1'b0;
    bus.cfg_load = 1'b0;
    bus.trk_in   = 8'hFF;

    // 1: reset state
    do_reset();
    expect_v("rst_pin_out", 32'h0);   check(32'(bus.pin_out));
    expect_v("rst_valid", 32'h0);     check(32'(bus.cfg_valid));
    expect_v("rst_err", 32'h0);       check(32'(bus.cfg_err));
    expect_v("rst_shift_o", 32'h0);   check(32'(bus.shift_o));

    // 2: basic routing, comb and registered
    bus.trk_in = 8'h00;
    shift_bits(32'(STREAM_A), 25);
    expect_v("t2_valid", 32'h1);
    expect_v("t2_err", 32'h0);
    expect_v("t2_pin_after_commit", 32'h00);
    commit();
    check(32'(bus.cfg_valid));
    check(32'(bus.cfg_err));
    check(32'(bus.pin_out));
    bus.trk_in = 8'b1000_0100;
    expect_v("t2_pin_comb_same_cycle", 32'h01);
    #1;
    check(32'(bus.pin_out));
    expect_v("t2_pin_reg_next_cycle", 32'h03);
    @(posedge clk); #1;
    check(32'(bus.pin_out));

    // 3: short load rejected, then full load accepted
    do_reset();
    bus.trk_in = 8'hFF;
    shift_bits(32'(STREAM_A >> 1), 24);
    expect_v("t3_short_err", 32'h1);
    expect_v("t3_short_valid", 32'h0);
    expect_v("t3_short_pin", 32'h00);
    commit();
    check(32'(bus.cfg_err));
    check(32'(bus.cfg_valid));
    check(32'(bus.pin_out));
    bus.trk_in = 8'b1000_0100;
    shift_bits(32'(STREAM_A), 25);
    expect_v("t3_full_err", 32'h0);
    expect_v("t3_full_valid", 32'h1);
    expect_v("t3_full_pin", 32'h01);
    commit();
    check(32'(bus.cfg_err));
    check(32'(bus.cfg_valid));
    check(32'(bus.pin_out));
    expect_v("t3_full_pin_reg", 32'h03);
    @(posedge clk); #1;
    check(32'(bus.pin_out));

    // 4: reprogram while routing is live; old routing holds during the shift
    bus.trk_in = 8'b1001_0101;
    for (int i = 24; i >= 0; i--) begin
      bus.shift_en = 1'b1;
      bus.shift_i  = STREAM_B[i];
      expect_v("t4_hold_old_routing", 32'h03);
      @(posedge clk); #1;
      check(32'(bus.pin_out));
    end
    bus.shift_en = 1'b0;
    expect_v("t4_new_routing_comb", 32'h12);
    commit();
    check(32'(bus.pin_out));
    expect_v("t4_new_routing_reg", 32'h16);
    @(posedge clk); #1;
    check(32'(bus.pin_out));
    bus.trk_in = 8'hFF;
    expect_v("t4_sel15_pin0_zero", 32'h0);
    #1;
    check(32'(bus.pin_out[0]));

    // 5a: chain latency and shift+load collision while an error is standing
    do_reset();
    expect_v("t5_err_setup", 32'h1);
    commit();
    check(32'(bus.cfg_err));
    pat = 4'b1011;
    for (int i = 1; i <= 28; i++) begin
      bus.shift_en = 1'b1;
      bus.shift_i  = (i <= 4) ? pat[4-i] : 1'b0;
      if (i >= 25) expect_v("t5_shift_o_latency", 32'(pat[3-(i-25)]));
      @(posedge clk); #1;
      if (i >= 25) check(32'(bus.shift_o));
    end
    bus.shift_en = 1'b1;
    bus.shift_i  = 1'b0;
    bus.cfg_load = 1'b1;
    expect_v("t5_collide_shifted", 32'h0);
    expect_v("t5_collide_err_kept", 32'h1);
    expect_v("t5_collide_valid", 32'h0);
    @(posedge clk); #1;
    bus.shift_en = 1'b0;
    bus.cfg_load = 1'b0;
    check(32'(bus.shift_o));
    check(32'(bus.cfg_err));
    check(32'(bus.cfg_valid));

    // 5b: load coinciding with the 25th shift is not a commit
    do_reset();
    bus.trk_in = 8'b1000_0100;
    shift_bits(32'(STREAM_A >> 1), 24);
    bus.shift_en = 1'b1;
    bus.shift_i  = STREAM_A[0];
    bus.cfg_load = 1'b1;
    expect_v("t5b_no_commit_valid", 32'h0);
    expect_v("t5b_no_commit_err", 32'h0);
    @(posedge clk); #1;
    bus.shift_en = 1'b0;
    bus.cfg_load = 1'b0;
    check(32'(bus.cfg_valid));
    check(32'(bus.cfg_err));
    expect_v("t5b_commit_valid", 32'h1);
    expect_v("t5b_commit_pin", 32'h01);
    commit();
    check(32'(bus.cfg_valid));
    check(32'(bus.pin_out));

    // 6: async reset in the middle of a load
    bus.trk_in = 8'b1001_0101;
    @(posedge clk); #1;
    expect_v("t6_pre_reset_pin", 32'h03);
    check(32'(bus.pin_out));
    shift_bits(32'(STREAM_B >> 14), 11);
    bus.shift_en = 1'b1;
    bus.shift_i  = STREAM_B[13];
    #2;
    rst_n = 1'b0;
    expect_v("t6_async_pin", 32'h0);
    expect_v("t6_async_valid", 32'h0);
    expect_v("t6_async_err", 32'h0);
    expect_v("t6_async_shift_o", 32'h0);
    #1;
    check(32'(bus.pin_out));
    check(32'(bus.cfg_valid));
    check(32'(bus.cfg_err));
    check(32'(bus.shift_o));
    bus.shift_en = 1'b0;
    bus.shift_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    shift_bits(32'(STREAM_B), 25);
    expect_v("t6_reload_valid", 32'h1);
    expect_v("t6_reload_err", 32'h0);
    expect_v("t6_reload_pin", 32'h12);
    commit();
    check(32'(bus.cfg_valid));
    check(32'(bus.cfg_err));
    check(32'(bus.pin_out));
    expect_v("t6_reload_pin_reg", 32'h16);
    @(posedge clk); #1;
    check(32'(bus.pin_out));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
